secure_serdes_decrypt_rx: RTL and testbench

Serial receive/decrypt block for the secure SerDes link. It accepts a framed bit-serial ciphertext stream plus a matching bit-serial key stream, MSB first, after a one-cycle start strobe. It checks an even-parity trailer bit, recovers the plaintext byte as ciphertext XOR key, and presents it in parallel with a held `done` flag, an acknowledge handshake and sticky error status. It sits at the far end of the link from the serial encrypt block and uses the same Tiny Tapeout top-level pin frame.

---
 rtl/secure_serdes_decrypt_rx.sv | 87 ++++++++
 tb/tb_secure_serdes_decrypt_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/secure_serdes_decrypt_rx.sv
// Bit-serial receive/decrypt: shifts in ciphertext and key MSB first, checks even parity,
// and presents plaintext = C ^ K with held done, ack handshake and sticky overrun.
module secure_serdes_decrypt_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  cipher_q;
  logic [7:0]  key_q;
  logic [7:0]  pt_q;
  logic        done_q;
  logic        busy_q;
  logic        perr_q;
  logic        ovr_q;
  logic [3:0]  fcnt_q;

  logic start, c_bit, k_bit, p_bit, ack;
  assign start = ui_in[0];
  assign c_bit = ui_in[1];
  assign k_bit = ui_in[2];
  assign p_bit = ui_in[3];
  assign ack   = ui_in[4];

  logic unused_inputs;
  assign unused_inputs = ^{uio_in, ui_in[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      cipher_q <= 8'h00;
      key_q    <= 8'h00;
      pt_q     <= 8'h00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      fcnt_q   <= 4'd0;
    end else if (ena) begin
      if (ack) begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShift;
            busy_q  <= 1'b1;
            cnt_q   <= 3'd7;
          end
        end
        StShift: begin
          cipher_q <= {cipher_q[6:0], c_bit};
          key_q    <= {key_q[6:0], k_bit};
          cnt_q    <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) state_q <= StParity;
        end
        StParity: begin
          // Completion overrides a coincident ack: the later assignments win.
          pt_q    <= cipher_q ^ key_q;
          perr_q  <= (^cipher_q) != p_bit;
          done_q  <= 1'b1;
          ovr_q   <= ovr_q | done_q;
          fcnt_q  <= fcnt_q + 4'd1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uo_out  = pt_q;
  assign uio_out = {fcnt_q, ovr_q, perr_q, busy_q, done_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_secure_serdes_decrypt_rx.sv
// Directed bench for secure_serdes_decrypt_rx: frame-level model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_secure_serdes_decrypt_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       start_b = 1'b0, c_b = 1'b0, k_b = 1'b0, p_b = 1'b0, ack_b = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {3'b000, ack_b, p_b, k_b, c_b, start_b};

  secure_serdes_decrypt_rx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  // Frame-level model: counts received bits and builds bytes arithmetically.
  bit m_busy = 0, m_done = 0, m_perr = 0, m_ovr = 0;
  int m_n = 0, m_c = 0, m_k = 0, m_pt = 0, m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_perr = 0; m_ovr = 0;
      m_n = 0; m_c = 0; m_k = 0; m_pt = 0; m_cnt = 0;
    end else if (ena) begin
      if (!m_busy) begin
        if (ack_b) begin m_done = 0; m_ovr = 0; end
        if (start_b) begin m_busy = 1; m_n = 0; m_c = 0; m_k = 0; end
      end else if (m_n < 8) begin
        if (ack_b) begin m_done = 0; m_ovr = 0; end
        m_c = (m_c * 2 + int'(c_b)) % 256;
        m_k = (m_k * 2 + int'(k_b)) % 256;
        m_n++;
      end else begin
        m_pt   = m_c ^ m_k;
        m_perr = (($countones(m_c) % 2) == 1) != p_b;
        m_ovr  = m_ovr || m_done;
        m_done = 1;
        m_cnt  = (m_cnt + 1) % 16;
        m_busy = 0;
      end
    end
  end

  logic [7:0] e_uo, e_uio;
  always @(posedge clk) begin
    #2;
    e_uo  = m_pt[7:0];
    e_uio = {m_cnt[3:0], m_ovr, m_perr, m_busy, m_done};
    checks++;
    if ({uo_out, uio_out, uio_oe} !== {e_uo, e_uio, 8'hFF}) begin
      errors++;
      $display("FAIL cycle @%0t: uo/uio/oe got %h/%h/%h expected %h/%h/ff",
               $time, uo_out, uio_out, uio_oe, e_uo, e_uio);
    end
    if (uio_out[1] === 1'b1) busy_cycles++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
  endtask

  // Drives one frame from a negedge; returns at the negedge after the parity edge.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] k, input logic p,
                            input logic ack_par, input logic start_hold, input int stall_bit);
    start_b = 1'b1;
    tick();
    start_b = start_hold;
    for (int i = 7; i >= 0; i--) begin
      if (i == stall_bit) begin
        ena = 1'b0;
        ack_b = 1'b1;
        repeat (3) tick();
        ena = 1'b1;
        ack_b = 1'b0;
      end
      c_b = c[i];
      k_b = k[i];
      tick();
    end
    start_b = 1'b0; c_b = 1'b0; k_b = 1'b0;
    p_b = p;
    ack_b = ack_par;
    tick();
    p_b = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] c, k;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    tick();

    // Basic frame and busy length
    busy_cycles = 0;
    send_frame(8'h02, 8'h03, 1'b1, 1'b0, 1'b0, -1);
    chk("s1_uo", uo_out, 8'h01);
    chk("s1_done", {7'd0, uio_out[0]}, 8'h01);
    chk("s1_perr", {7'd0, uio_out[2]}, 8'h00);
    chk("s1_fcnt", {4'd0, uio_out[7:4]}, 8'h01);
    chk("s1_busy_len", busy_cycles[7:0], 8'd9);

    // Bad parity still delivers the byte; next good frame clears the error
    send_frame(8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0, -1);
    chk("s2_uo", uo_out, 8'h99);
    chk("s2_perr", {7'd0, uio_out[2]}, 8'h01);
    chk("s2_done", {7'd0, uio_out[0]}, 8'h01);
    ack_pulse();
    chk("s2_ack_done", {7'd0, uio_out[0]}, 8'h00);
    send_frame(8'h02, 8'h03, 1'b1, 1'b0, 1'b0, -1);
    chk("s2_perr_clr", {7'd0, uio_out[2]}, 8'h00);

    // Back-to-back frames without ack
    ack_pulse();
    send_frame(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, -1);
    chk("s3_uo1", uo_out, 8'hF0);
    chk("s3_ovr1", {7'd0, uio_out[3]}, 8'h00);
    send_frame(8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, -1);
    chk("s3_uo2", uo_out, 8'hAA);
    chk("s3_ovr2", {7'd0, uio_out[3]}, 8'h01);
    chk("s3_done2", {7'd0, uio_out[0]}, 8'h01);
    ack_pulse();
    chk("s3_ack_clr", uio_out & 8'h09, 8'h00);

    // Ack on the parity edge is dropped; start held through SHIFT is ignored
    send_frame(8'h3C, 8'h81, 1'b0, 1'b1, 1'b1, -1);
    chk("s4_uo", uo_out, 8'hBD);
    chk("s4_done", {7'd0, uio_out[0]}, 8'h01);
    chk("s4_fcnt", {4'd0, uio_out[7:4]}, 8'h06);
    ack_pulse();
    chk("s4_ack_late", {7'd0, uio_out[0]}, 8'h00);

    // Reset in the middle of a frame
    start_b = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      c_b = 1'b1; k_b = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("s5_rst_uo", uo_out, 8'h00);
    chk("s5_rst_uio", uio_out, 8'h00);
    start_b = 1'b0; c_b = 1'b0;
    rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    chk("s5_uo", uo_out, 8'h66);
    chk("s5_fcnt", {4'd0, uio_out[7:4]}, 8'h01);
    chk("s5_perr", {7'd0, uio_out[2]}, 8'h00);

    // Frame counter wrap, last frame stalled by ena with an ignored ack
    for (int j = 0; j < 14; j++) begin
      c = 8'(j * 17 + 3);
      k = 8'(j * 29 + 101);
      send_frame(c, k, ^c, 1'b0, 1'b0, -1);
    end
    chk("s6_fcnt15", {4'd0, uio_out[7:4]}, 8'h0F);
    busy_cycles = 0;
    send_frame(8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 4);
    chk("s6_uo", uo_out, 8'h5A);
    chk("s6_fcnt_wrap", {4'd0, uio_out[7:4]}, 8'h00);
    chk("s6_ovr", {7'd0, uio_out[3]}, 8'h01);
    chk("s6_busy_len", busy_cycles[7:0], 8'd12);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
